rx_word_packer: RTL and testbench
=================================

# rx_word_packer

Read-side controller for the 8-bit `rx_fifo` in the UART receive path. It drains bytes from the FIFO by sequencing `r_enable`, packs them little-endian into a `BYTES`-wide word, and presents the word on a valid/ready interface to the downstream consumer. Partial words are emitted on an explicit flush or, when configured, after an idle timeout.

## Interface
- `BYTES`, 4: bytes per word; legal range 2..8.
- `TIMEOUT_CYCLES`, 64: idle cycles after the last captured byte before a partial word is emitted; legal range 2..1023; used only with the timeout feature.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  `rx_fifo` empty flag.
- `fifo_r_data`  in  8  `rx_fifo` head byte; first-word-fall-through, valid whenever `fifo_empty`=0.
- `fifo_r_enable`  out  1  pops the FIFO head on the rising edge where it is high; combinational.
- `flush`  in  1  single-cycle request to emit the current partial word.
- `word_data`  out  8*BYTES  packed word; byte 0 (first received) in bits [7:0]; unfilled lanes are 0.
- `word_bytes`  out  $clog2(BYTES+1)  number of valid bytes in `word_data`, 1..BYTES.
- `word_valid`  out  1  word available; registered.
- `word_ready`  in  1  consumer accepts the word.

## Operation
- There are two states: COLLECT (the reset state) and EMIT.
- **COLLECT**
  - `fifo_r_enable` = !`fifo_empty`.
  - On an edge with `fifo_r_enable`=1, `fifo_r_data` is written into lane `count` and `count` increments.
  - When `count` reaches BYTES, the next state is EMIT.
- **Flush in COLLECT**
  - `flush`=1 with (`count` + byte taken this cycle) > 0 moves the block to EMIT.
  - Any byte taken in the same cycle is included in the emitted word.
  - `flush` with nothing held and nothing taken is ignored.
- **EMIT**
  - `word_valid`=1 and `fifo_r_enable`=0.
  - `word_data` and `word_bytes` are stable until acceptance.
  - On an edge with `word_ready`=1, all lanes clear to 0, `count` returns to 0, and the state returns to COLLECT.
  - `flush` is ignored in EMIT.
- `word_bytes` equals `count` while in EMIT and is 0 otherwise.
- The FIFO never pops in EMIT, so back-pressure fills `rx_fifo`. Overrun handling belongs to the FIFO and the receiver, not this block.

## Timing
- **Reset:**
  - `word_valid`=0, `word_data`=0, `word_bytes`=0.
  - `count`=0, timer=0, state COLLECT.
  - `fifo_r_enable` is low during reset because `rx_fifo` shares `n_rst` and is empty.
- **Mid-operation reset:** asserting `n_rst` discards any partial or pending word immediately, asynchronously.
- **Latency:** the edge that captures the BYTES-th byte also raises `word_valid`.
- **Throughput:** with `word_ready` held high and the FIFO non-empty, one word is produced every BYTES+1 cycles (BYTES capture cycles plus one EMIT cycle).
- **Acceptance:** `word_valid` falls on the acceptance edge. Capture resumes in the following cycle.
- **Simultaneous events:**
  - A byte capture and a timeout expiry in the same cycle: the byte wins, the timer clears, and no emit occurs.
  - A flush on the cycle that fills the last lane: a single full word is emitted.

## Configuration
- Macro: `RX_WORD_PACKER_TIMEOUT_EN`.
- **Defined:**
  - A timer counts COLLECT cycles with `count`>0 and no byte captured.
  - The timer clears on every capture and on leaving COLLECT.
  - When the timer reaches TIMEOUT_CYCLES-1 and a further idle cycle occurs, the block enters EMIT with the partial word. `word_valid` therefore rises exactly TIMEOUT_CYCLES edges after the last capture edge.
- **Undefined:**
  - No timer is instantiated and `TIMEOUT_CYCLES` is unused.
  - Partial words leave only via `flush`; a partial word otherwise waits indefinitely for more bytes.

## Test plan
- **Full word:** BYTES=4, `word_ready`=1. Push 8'h11, 8'h22, 8'h33, 8'h44 into the FIFO. Required response:
  - `fifo_r_enable` is high for 4 consecutive cycles.
  - `word_data`=32'h44332211, `word_bytes`=4, `word_valid` high for exactly 1 cycle.
- **Back-pressure:** `word_ready`=0 after a full word. Required response:
  - `word_valid` stays high and `word_data` is stable.
  - `fifo_r_enable`=0 while 3 more bytes accumulate in the FIFO.
  - After `word_ready` rises, capture resumes in the following cycle.
- **Flush:** push 8'hA5, 8'h5A, then pulse `flush` 3 cycles later. Required response: `word_data`=32'h00005AA5, `word_bytes`=2. A second `flush` while empty produces no word.
- **Timeout:** macro defined, TIMEOUT_CYCLES=8. Push one byte 8'hC3. Required response: `word_valid` rises 8 edges after the capture edge, with `word_bytes`=1 and `word_data`=32'h000000C3. With the macro undefined, no word appears within 100 cycles.
- **Reset:** assert `n_rst` while in EMIT and again with 2 bytes held. Required response: all outputs go to 0 immediately and asynchronously. After release, the next 4 bytes form a clean word with no stale lanes.

Source files
------------

// File: rtl/rx_word_packer.sv
// Drains bytes from rx_fifo, packs them little-endian into BYTES-wide words and
// presents them on valid/ready. Optional idle timeout: RX_WORD_PACKER_TIMEOUT_EN.
module rx_word_packer #(
   parameter int unsigned BYTES          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                         clk,
   input  logic                         n_rst,
   input  logic                         fifo_empty,
   input  logic [7:0]                   fifo_r_data,
   output logic                         fifo_r_enable,
   input  logic                         flush,
   output logic [8*BYTES-1:0]           word_data,
   output logic [$clog2(BYTES+1)-1:0]   word_bytes,
   output logic                         word_valid,
   input  logic                         word_ready
);

   localparam int unsigned DW = 8 * BYTES;
   localparam int unsigned CW = $clog2(BYTES + 1);

   if (BYTES < 2 || BYTES > 8) begin : g_bad_bytes
      $error("rx_word_packer: BYTES must be 2..8");
   end
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
      $error("rx_word_packer: TIMEOUT_CYCLES must be 2..1023");
   end

   typedef enum logic {COLLECT, EMIT} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [DW-1:0]   data_q,  data_d;
   logic [CW-1:0]   bytes_q, bytes_d;
   logic            valid_q, valid_d;
   logic            take;
   logic            go_emit;
   logic            timeout_c;

   // Pop only while collecting; count never reaches BYTES in COLLECT.
   assign take          = (state_q == COLLECT) && !fifo_empty;
   assign fifo_r_enable = take;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      data_d  = data_q;
      valid_d = valid_q;
      bytes_d = bytes_q;
      go_emit = 1'b0;
      case (state_q)
         COLLECT: begin
            if (take) begin
               for (int unsigned i = 0; i < BYTES; i++) begin
                  if (count_q == CW'(i)) data_d[8*i +: 8] = fifo_r_data;
               end
               count_d = count_q + CW'(1);
            end
            // A byte taken this cycle counts toward a flush and beats a timeout.
            go_emit = (take && (count_q == CW'(BYTES - 1)))
                    || (flush && (take || (count_q != '0)))
                    || timeout_c;
            if (go_emit) begin
               state_d = EMIT;
               valid_d = 1'b1;
               bytes_d = count_d;
            end
         end
         EMIT: begin
            if (word_ready) begin
               state_d = COLLECT;
               count_d = '0;
               data_d  = '0;
               valid_d = 1'b0;
               bytes_d = '0;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= COLLECT;
         count_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         bytes_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         bytes_q <= bytes_d;
      end
   end

`ifdef RX_WORD_PACKER_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

   logic [TW-1:0] timer_q, timer_d;

   // Idle timer: runs only while a partial word is held and nothing arrives.
   assign timeout_c = (state_q == COLLECT) && !take && (count_q != '0)
                      && (timer_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      timer_d = timer_q;
      if ((state_q != COLLECT) || take || go_emit) begin
         timer_d = '0;
      end else if (count_q != '0) begin
         timer_d = timer_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) timer_q <= '0;
      else        timer_q <= timer_d;
   end
`else
   assign timeout_c = 1'b0;
`endif

   assign word_data  = data_q;
   assign word_bytes = bytes_q;
   assign word_valid = valid_q;

endmodule

// File: tb/tb_rx_word_packer.sv
// Directed bench for rx_word_packer (BYTES=4, TIMEOUT_CYCLES=8) with a
// first-word-fall-through FIFO model feeding it.
module tb_rx_word_packer;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        fifo_empty;
   logic [7:0]  fifo_r_data;
   logic        fifo_r_enable;
   logic        flush;
   logic [31:0] word_data;
   logic [2:0]  word_bytes;
   logic        word_valid;
   logic        word_ready;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mem [0:63];
   int         wr_ptr = 0;
   int         rd_ptr = 0;

   always #5 clk = ~clk;

   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_r_data = mem[rd_ptr % 64];

   always @(posedge clk) begin
      if (fifo_r_enable && !fifo_empty) rd_ptr <= rd_ptr + 1;
   end

   rx_word_packer #(.BYTES(4), .TIMEOUT_CYCLES(8)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .fifo_empty    (fifo_empty),
      .fifo_r_data   (fifo_r_data),
      .fifo_r_enable (fifo_r_enable),
      .flush         (flush),
      .word_data     (word_data),
      .word_bytes    (word_bytes),
      .word_valid    (word_valid),
      .word_ready    (word_ready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr % 64] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic expect_word(input string tag, input logic [31:0] d, input logic [2:0] n);
      check({tag, "_valid"}, 64'(word_valid), 64'(1'b1));
      check({tag, "_data"},  64'(word_data),  64'(d));
      check({tag, "_bytes"}, 64'(word_bytes), 64'(n));
   endtask

   task automatic expect_idle(input string tag);
      check({tag, "_valid"}, 64'(word_valid), 64'(1'b0));
      check({tag, "_data"},  64'(word_data),  64'(0));
      check({tag, "_bytes"}, 64'(word_bytes), 64'(0));
   endtask

   initial begin
      logic seen;
      n_rst      = 1'b0;
      flush      = 1'b0;
      word_ready = 1'b1;
      repeat (2) @(negedge clk);
      expect_idle("reset");
      check("reset_ren", 64'(fifo_r_enable), 64'(1'b0));
      n_rst = 1'b1;
      @(negedge clk);

      // Full word, consumer always ready.
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      #1;
      for (int i = 0; i < 4; i++) begin
         check("full_ren", 64'(fifo_r_enable), 64'(1'b1));
         check("full_novalid", 64'(word_valid), 64'(1'b0));
         @(negedge clk);
      end
      expect_word("full", 32'h44332211, 3'd4);
      @(negedge clk);
      expect_idle("full_after");

      // Back-pressure: word held, FIFO fills behind it.
      word_ready = 1'b0;
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      repeat (4) @(negedge clk);
      push(8'h05); push(8'h06); push(8'h07);
      #1;
      for (int i = 0; i < 3; i++) begin
         expect_word("bp_hold", 32'h04030201, 3'd4);
         check("bp_ren", 64'(fifo_r_enable), 64'(1'b0));
         @(negedge clk);
      end
      word_ready = 1'b1;
      #1;
      check("bp_ren_accept", 64'(fifo_r_enable), 64'(1'b0));
      @(negedge clk);
      check("bp_resume_valid", 64'(word_valid), 64'(1'b0));
      for (int i = 0; i < 3; i++) begin
         check("bp_resume_ren", 64'(fifo_r_enable), 64'(1'b1));
         @(negedge clk);
      end
      check("bp_drained_ren", 64'(fifo_r_enable), 64'(1'b0));
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      expect_word("bp_flush", 32'h00070605, 3'd3);
      @(negedge clk);
      expect_idle("bp_flush_after");

      // Flush of a two-byte partial word, then a flush with nothing held.
      push(8'hA5); push(8'h5A);
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      expect_word("flush2", 32'h00005AA5, 3'd2);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_empty_1", 64'(word_valid), 64'(1'b0));
      repeat (2) @(negedge clk);
      check("flush_empty_3", 64'(word_valid), 64'(1'b0));

      // Flush in the same cycle as the only byte: that byte is emitted.
      push(8'h99);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      expect_word("flush_take", 32'h00000099, 3'd1);
      @(negedge clk);

      // Flush on the cycle that fills the last lane: one full word only.
      push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      expect_word("flush_full", 32'hD4D3D2D1, 3'd4);
      @(negedge clk);
      expect_idle("flush_full_after");
      repeat (2) @(negedge clk);
      check("flush_full_single", 64'(word_valid), 64'(1'b0));

`ifdef RX_WORD_PACKER_TIMEOUT_EN
      // Partial word emitted exactly TIMEOUT_CYCLES edges after the capture edge.
      push(8'hC3);
      @(negedge clk);
      seen = 1'b0;
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         if (word_valid) seen = 1'b1;
      end
      check("timeout_early", 64'(seen), 64'(1'b0));
      @(negedge clk);
      expect_word("timeout", 32'h000000C3, 3'd1);
      @(negedge clk);
`else
      // Without the timer a partial word waits until flushed.
      push(8'hC3);
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (word_valid) seen = 1'b1;
      end
      check("no_timeout", 64'(seen), 64'(1'b0));
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      expect_word("no_timeout_flush", 32'h000000C3, 3'd1);
      @(negedge clk);
`endif

      // Asynchronous reset while a word is pending.
      word_ready = 1'b0;
      push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
      repeat (4) @(negedge clk);
      expect_word("rst_emit_pre", 32'hE4E3E2E1, 3'd4);
      #2 n_rst = 1'b0;
      #1 expect_idle("rst_emit");
      @(negedge clk);
      n_rst = 1'b1;
      word_ready = 1'b1;

      // Asynchronous reset with two bytes held.
      push(8'hB1); push(8'hB2);
      repeat (3) @(negedge clk);
      #2 n_rst = 1'b0;
      #1 expect_idle("rst_partial");
      check("rst_partial_ren", 64'(fifo_r_enable), 64'(1'b0));
      @(negedge clk);
      n_rst = 1'b1;

      push(8'h0A); push(8'h0B); push(8'h0C); push(8'h0D);
      repeat (3) @(negedge clk);
      check("rst_clean_novalid", 64'(word_valid), 64'(1'b0));
      @(negedge clk);
      expect_word("rst_clean", 32'h0D0C0B0A, 3'd4);
      @(negedge clk);
      expect_idle("rst_clean_after");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
